ysyx_25030081_wbu: RTL and testbench
====================================

# ysyx_25030081_wbu

Writeback unit and register scoreboard for the single-issue core; the block drives the register file write port (wen/waddr/wdata). It accepts completed results from the execute unit (EXU) and load/store unit (LSU) over valid/ready handshakes and arbitrates between them round-robin. Results are registered and written into the register file one per cycle. It also tracks in-flight destination registers so decode can detect RAW/WAW hazards and stall.

## Interface
- RF_ADDR_WIDTH, 5, register index width; scoreboard has 2**RF_ADDR_WIDTH bits
- DATA_WIDTH, 32, result / register data width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- iss_valid  in  1  decode issues an instruction that writes iss_rd
- iss_rd  in  RF_ADDR_WIDTH  destination register of the issued instruction
- iss_ready  out  1  issue accepted this cycle (iss_fire = iss_valid & iss_ready)
- rs1, rs2  in  RF_ADDR_WIDTH  decode source registers for hazard check
- rs1_busy, rs2_busy  out  1  source register has a pending write
- exu_valid, exu_ready  in/out  1  EXU result handshake
- exu_rd, exu_data  in  RF_ADDR_WIDTH / DATA_WIDTH  EXU destination and result
- lsu_valid, lsu_ready  in/out  1  LSU result handshake
- lsu_rd, lsu_data  in  RF_ADDR_WIDTH / DATA_WIDTH  LSU destination and load data
- rf_wen  out  1  register file write enable
- rf_waddr  out  RF_ADDR_WIDTH  register file write address
- rf_wdata  out  DATA_WIDTH  register file write data
- retire_cnt  out  32  count of committed results, wraps at 2**32

## Operation
- Scoreboard: busy[0..2**RF_ADDR_WIDTH-1], registered. busy[0] is always 0.
- iss_ready = ~busy[iss_rd]. This uses registered state only, so WAW conflicts stall and a register is never set while it is busy.
- On iss_fire with iss_rd != 0: busy[iss_rd] <= 1. If iss_rd == 0, busy is unchanged and iss_ready = 1.
- rs1_busy = busy[rs1]; rs2_busy = busy[rs2]. Both are combinational from registered busy, so x0 always reads 0.
- Arbiter: round-robin with a 1-bit last-grant pointer lg (0=EXU, 1=LSU).
  - Only one port valid: that port is granted.
  - Both valid: the port not equal to lg is granted, then lg updates to the granted port.
- exu_ready and lsu_ready equal their grant. They are combinational on both valids and are never high when the corresponding valid is low.
- An accepted result is latched into the output register: wb_valid, wb_rd, wb_data.
- Output stage (commit cycle):
  - rf_wen = wb_valid & (wb_rd != 0); rf_waddr = wb_rd; rf_wdata = wb_data.
  - If wb_valid: busy[wb_rd] <= 0 and retire_cnt <= retire_cnt + 1 (modulo 2**32). A result to x0 still counts.
- The output stage drains every cycle, so it never back-pressures; at most one handshake completes per cycle.
- Simultaneous events:
  - Issue to rd A and commit to rd B in the same cycle: both are applied.
  - Commit clearing rd A while iss_rd = A: iss_ready is 0 that cycle. The issue is accepted the next cycle.
- A completion for a non-busy rd is a protocol violation. It is still written and counted; busy stays 0.
- Reset: busy all 0, wb_valid 0, wb_rd 0, wb_data 0, lg 1 (EXU wins first tie), retire_cnt 0.
  - Resulting outputs: rf_wen 0, rf_waddr 0, rf_wdata 0, iss_ready 1, rs1_busy/rs2_busy 0.
  - rst asserted mid-operation discards any latched result; no rf write occurs in the cycle after rst.

## Timing
- Accept (valid & ready at edge N) -> rf write at edge N+1; busy clears at the same edge N+1.
- A register-file read in cycle N+1 (after edge N+1) sees the new value, and rs*_busy is 0 in that cycle.
- Issue at edge N -> rs*_busy and iss_ready reflect it in cycle N+1 onward.
- Throughput: one result per cycle. Under continuous contention each port gets every other cycle.

## Test plan
- After reset: rf_wen=0, retire_cnt=0, iss_ready=1. Issue rd=5 -> next cycle rs1=5 gives rs1_busy=1 and iss_rd=5 gives iss_ready=0.
- Issue rd=5, EXU result rd=5 data=0xDEADBEEF -> one cycle later rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, busy[5] clears, retire_cnt=1.
- EXU rd=3 and LSU rd=4 valid in the same cycle, held for 4 cycles with fresh data:
  - Grants alternate EXU, LSU, EXU, LSU.
  - Only one ready is high per cycle.
  - The rf write order matches the grants.
- Issue rd=0, result rd=0 data=0x1 -> iss_ready stays 1, rf_wen stays 0, retire_cnt increments.
- retire_cnt preset near wrap (drive 2**32-1 commits or force) -> next commit gives 0.
- Issue rd=7 and accept an EXU result, then assert rst on the cycle the result is latched:
  - No rf write occurs.
  - busy[7]=0.
  - All outputs return to their reset values.

Source files
------------

// File: rtl/ysyx_25030081_wbu.sv
// Writeback unit: round-robin EXU/LSU result arbiter, one-entry output
// register driving the RF write port, and the in-flight rd scoreboard.
module ysyx_25030081_wbu #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_valid,
    input  logic [RF_ADDR_WIDTH-1:0] iss_rd,
    output logic                     iss_ready,
    input  logic [RF_ADDR_WIDTH-1:0] rs1,
    input  logic [RF_ADDR_WIDTH-1:0] rs2,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    input  logic                     exu_valid,
    output logic                     exu_ready,
    input  logic [RF_ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0]    exu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [RF_ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    output logic                     rf_wen,
    output logic [RF_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    output logic [31:0]              retire_cnt
);

    localparam int NREG = 1 << RF_ADDR_WIDTH;

    logic [NREG-1:0]          busy;
    logic [NREG-1:0]          busy_n;
    logic                     lg;
    logic                     wb_valid;
    logic [RF_ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]    wb_data;
    logic                     iss_fire;
    logic                     exu_gnt;
    logic                     lsu_gnt;
    logic                     accept;

    // Hazard view and issue acceptance come from registered busy only
    always_comb begin
        iss_ready = ~busy[iss_rd];
        iss_fire  = iss_valid & iss_ready;
        rs1_busy  = busy[rs1];
        rs2_busy  = busy[rs2];
    end

    // Round-robin grant; a tie goes to the port that did not win last
    always_comb begin
        exu_gnt   = exu_valid & (~lsu_valid | lg);
        lsu_gnt   = lsu_valid & (~exu_valid | ~lg);
        exu_ready = exu_gnt;
        lsu_ready = lsu_gnt;
        accept    = exu_gnt | lsu_gnt;
    end

    // Scoreboard update: commit clears, issue sets, x0 never busy
    always_comb begin
        busy_n = busy;
        if (wb_valid)
            busy_n[wb_rd] = 1'b0;
        if (iss_fire && (iss_rd != '0))
            busy_n[iss_rd] = 1'b1;
        busy_n[0] = 1'b0;
    end

    // Commit port is a straight view of the output register
    always_comb begin
        rf_wen   = wb_valid & (wb_rd != '0);
        rf_waddr = wb_rd;
        rf_wdata = wb_data;
    end

    // State: scoreboard, arbiter pointer, output register, retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            lg         <= 1'b1;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            retire_cnt <= '0;
        end else begin
            busy     <= busy_n;
            wb_valid <= accept;
            if (exu_valid && lsu_valid)
                lg <= lsu_gnt;
            if (accept) begin
                wb_rd   <= exu_gnt ? exu_rd : lsu_rd;
                wb_data <= exu_gnt ? exu_data : lsu_data;
            end
            if (wb_valid)
                retire_cnt <= retire_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ysyx_25030081_wbu.sv
// Directed bench for ysyx_25030081_wbu: reset, scoreboard, commit timing,
// round-robin contention, x0 handling, counter wrap and mid-flight reset.
module tb_ysyx_25030081_wbu;

    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] retire_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    ysyx_25030081_wbu #(.RF_ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .exu_valid(exu_valid), .exu_ready(exu_ready),
        .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        iss_rd = 5'd5;
        rs1 = 5'd5;
        rs2 = 5'd0;
        #1;
        total_cnt++;
        if (rf_wen !== 1'b0) $display("FAIL reset_rf_wen got %b want 0", rf_wen);
        else pass_cnt++;
        total_cnt++;
        if (rf_waddr !== 5'd0) $display("FAIL reset_waddr got %0d want 0", rf_waddr);
        else pass_cnt++;
        total_cnt++;
        if (rf_wdata !== 32'd0) $display("FAIL reset_wdata got %h want 0", rf_wdata);
        else pass_cnt++;
        total_cnt++;
        if (retire_cnt !== 32'd0) $display("FAIL reset_retire got %0d want 0", retire_cnt);
        else pass_cnt++;
        total_cnt++;
        if (iss_ready !== 1'b1) $display("FAIL reset_iss_ready got %b want 1", iss_ready);
        else pass_cnt++;
        total_cnt++;
        if (rs1_busy !== 1'b0) $display("FAIL reset_rs1_busy got %b want 0", rs1_busy);
        else pass_cnt++;
    endtask

    task automatic test_issue_busy();
        iss_valid = 1'b1;
        iss_rd = 5'd5;
        step();
        iss_valid = 1'b0;
        rs1 = 5'd5;
        rs2 = 5'd6;
        #1;
        total_cnt++;
        if (rs1_busy !== 1'b1) $display("FAIL issue_rs1_busy got %b want 1", rs1_busy);
        else pass_cnt++;
        total_cnt++;
        if (rs2_busy !== 1'b0) $display("FAIL issue_rs2_busy got %b want 0", rs2_busy);
        else pass_cnt++;
        total_cnt++;
        if (iss_ready !== 1'b0) $display("FAIL issue_waw_ready got %b want 0", iss_ready);
        else pass_cnt++;
    endtask

    task automatic test_exu_commit();
        exu_valid = 1'b1;
        exu_rd = 5'd5;
        exu_data = 32'hDEAD_BEEF;
        #1;
        total_cnt++;
        if ({exu_ready, lsu_ready} !== 2'b10)
            $display("FAIL commit_ready got %b want 10", {exu_ready, lsu_ready});
        else pass_cnt++;
        step();
        exu_valid = 1'b0;
        #1;
        total_cnt++;
        if ({rf_wen, rf_waddr} !== {1'b1, 5'd5})
            $display("FAIL commit_wen_addr got %b/%0d want 1/5", rf_wen, rf_waddr);
        else pass_cnt++;
        total_cnt++;
        if (rf_wdata !== 32'hDEAD_BEEF)
            $display("FAIL commit_wdata got %h want deadbeef", rf_wdata);
        else pass_cnt++;
        total_cnt++;
        if ({rs1_busy, iss_ready} !== 2'b10)
            $display("FAIL commit_cycle_busy got %b want 10", {rs1_busy, iss_ready});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({rf_wen, rs1_busy, iss_ready} !== 3'b001)
            $display("FAIL commit_after got %b want 001", {rf_wen, rs1_busy, iss_ready});
        else pass_cnt++;
        total_cnt++;
        if (retire_cnt !== 32'd1) $display("FAIL commit_retire got %0d want 1", retire_cnt);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        logic [1:0]  exp_rdy;
        logic [4:0]  exp_rd;
        logic [31:0] exp_d;
        iss_valid = 1'b1;
        iss_rd = 5'd3;
        step();
        iss_rd = 5'd4;
        step();
        iss_valid = 1'b0;
        exu_valid = 1'b1;
        lsu_valid = 1'b1;
        exu_rd = 5'd3;
        lsu_rd = 5'd4;
        for (int i = 0; i < 4; i++) begin
            exu_data = 32'h1000 + i;
            lsu_data = 32'h2000 + i;
            #1;
            exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
            total_cnt++;
            if ({exu_ready, lsu_ready} !== exp_rdy)
                $display("FAIL rr_grant%0d got %b want %b", i, {exu_ready, lsu_ready}, exp_rdy);
            else pass_cnt++;
            step();
            exp_rd = (i % 2 == 0) ? 5'd3 : 5'd4;
            exp_d = (i % 2 == 0) ? 32'h1000 + i : 32'h2000 + i;
            total_cnt++;
            if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, exp_rd, exp_d})
                $display("FAIL rr_write%0d got %b/%0d/%h want 1/%0d/%h",
                         i, rf_wen, rf_waddr, rf_wdata, exp_rd, exp_d);
            else pass_cnt++;
        end
        exu_valid = 1'b0;
        lsu_valid = 1'b0;
        step();
        total_cnt++;
        if ({rf_wen, retire_cnt} !== {1'b0, 32'd5})
            $display("FAIL rr_retire got %b/%0d want 0/5", rf_wen, retire_cnt);
        else pass_cnt++;
    endtask

    task automatic test_x0();
        iss_valid = 1'b1;
        iss_rd = 5'd0;
        #1;
        total_cnt++;
        if (iss_ready !== 1'b1) $display("FAIL x0_iss_ready got %b want 1", iss_ready);
        else pass_cnt++;
        step();
        iss_valid = 1'b0;
        rs1 = 5'd0;
        exu_valid = 1'b1;
        exu_rd = 5'd0;
        exu_data = 32'h1;
        #1;
        total_cnt++;
        if ({iss_ready, rs1_busy} !== 2'b10)
            $display("FAIL x0_not_busy got %b want 10", {iss_ready, rs1_busy});
        else pass_cnt++;
        step();
        exu_valid = 1'b0;
        #1;
        total_cnt++;
        if (rf_wen !== 1'b0) $display("FAIL x0_no_write got %b want 0", rf_wen);
        else pass_cnt++;
        step();
        total_cnt++;
        if (retire_cnt !== 32'd6) $display("FAIL x0_retire got %0d want 6", retire_cnt);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        exu_valid = 1'b1;
        exu_rd = 5'd9;
        exu_data = 32'h55;
        step();
        exu_valid = 1'b0;
        step();
        total_cnt++;
        if (retire_cnt !== 32'd0) $display("FAIL wrap_retire got %h want 0", retire_cnt);
        else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        iss_valid = 1'b1;
        iss_rd = 5'd7;
        step();
        iss_valid = 1'b0;
        rs1 = 5'd7;
        rs2 = 5'd7;
        #1;
        total_cnt++;
        if (rs1_busy !== 1'b1) $display("FAIL rst_pre_busy got %b want 1", rs1_busy);
        else pass_cnt++;
        exu_valid = 1'b1;
        exu_rd = 5'd7;
        exu_data = 32'h77;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exu_valid = 1'b0;
        #1;
        total_cnt++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0})
            $display("FAIL rst_rf got %b/%0d/%h want 0/0/0", rf_wen, rf_waddr, rf_wdata);
        else pass_cnt++;
        total_cnt++;
        if ({rs1_busy, rs2_busy, iss_ready} !== 3'b001)
            $display("FAIL rst_busy got %b want 001", {rs1_busy, rs2_busy, iss_ready});
        else pass_cnt++;
        total_cnt++;
        if (retire_cnt !== 32'd0) $display("FAIL rst_retire got %0d want 0", retire_cnt);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({rf_wen, retire_cnt} !== {1'b0, 32'd0})
            $display("FAIL rst_after got %b/%0d want 0/0", rf_wen, retire_cnt);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        iss_valid = 1'b0;
        iss_rd = '0;
        rs1 = '0;
        rs2 = '0;
        exu_valid = 1'b0;
        exu_rd = '0;
        exu_data = '0;
        lsu_valid = 1'b0;
        lsu_rd = '0;
        lsu_data = '0;
        step();
        step();
        rst = 1'b0;
        test_reset();
        test_issue_busy();
        test_exu_commit();
        test_contention();
        test_x0();
        test_wrap();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
